// File: rtl/regfile_bist.sv
// rtl/regfile_bist.sv - register file built-in self-test master (optional REGBIST_INVERT_PASS_EN)
module regfile_bist #(
  parameter logic [31:0] SEED        = 32'h0000_0000,
  parameter int          ZERO_REG_HW = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_in,
  output logic        enable_out,
  output logic [4:0]  writeReg_out,
  output logic [31:0] writeData_out,
  output logic [4:0]  readReg1_out,
  output logic [4:0]  readReg2_out,
  input  logic [31:0] data1_in,
  input  logic [31:0] data2_in,
  output logic        busy_out,
  output logic        done_out,
  output logic        pass_out,
  output logic [6:0]  fail_count_out,
  output logic [4:0]  first_fail_out
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

  state_t     state;
  logic [4:0] idx;
  logic [4:0] idx_nxt;
  logic [4:0] rd1_idx;
  logic [4:0] rd2_idx;
  logic       mis1;
  logic       mis2;
  logic [7:0] fc_sum;
  logic [6:0] fc_next;
  logic       last_pass;

`ifdef REGBIST_INVERT_PASS_EN
  // Set during the second, complemented write/read pass
  logic invert;
`else
  localparam logic invert = 1'b0;
`endif

  // Pattern a register should hold; reg 0 reads back 0 when hardwired
  function automatic logic [31:0] expected(input logic [4:0] i, input logic inv);
    logic [31:0] p;
    p = {27'b0, i} ^ SEED;
    if (inv) p = ~p;
    if (i == 5'd0 && ZERO_REG_HW != 0) p = 32'h0;
    return p;
  endfunction

  // Read-pair compare and saturating mismatch accumulation
  always_comb begin
    idx_nxt = idx + 5'd1;
    rd1_idx = {idx[3:0], 1'b0};
    rd2_idx = {idx[3:0], 1'b1};
    mis1    = (state == READ) && (data1_in != expected(rd1_idx, invert));
    mis2    = (state == READ) && (data2_in != expected(rd2_idx, invert));
    fc_sum  = {1'b0, fail_count_out} + {7'b0, mis1} + {7'b0, mis2};
    fc_next = (fc_sum > 8'd127) ? 7'd127 : fc_sum[6:0];
`ifdef REGBIST_INVERT_PASS_EN
    last_pass = invert;
`else
    last_pass = 1'b1;
`endif
  end

  // Test sequencer with registered port drive and result capture
  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= IDLE;
      idx            <= 5'd0;
      enable_out     <= 1'b0;
      writeReg_out   <= 5'd0;
      writeData_out  <= 32'h0;
      readReg1_out   <= 5'd0;
      readReg2_out   <= 5'd0;
      busy_out       <= 1'b0;
      done_out       <= 1'b0;
      pass_out       <= 1'b0;
      fail_count_out <= 7'd0;
      first_fail_out <= 5'd0;
`ifdef REGBIST_INVERT_PASS_EN
      invert         <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start_in) begin
            state          <= WRITE;
            idx            <= 5'd0;
            busy_out       <= 1'b1;
            done_out       <= 1'b0;
            pass_out       <= 1'b0;
            fail_count_out <= 7'd0;
            first_fail_out <= 5'd0;
            enable_out     <= 1'b1;
            writeReg_out   <= 5'd0;
            writeData_out  <= expected(5'd0, 1'b0);
`ifdef REGBIST_INVERT_PASS_EN
            invert         <= 1'b0;
`endif
          end
        end
        WRITE: begin
          if (idx == 5'd31) begin
            state         <= READ;
            idx           <= 5'd0;
            enable_out    <= 1'b0;
            writeReg_out  <= 5'd0;
            writeData_out <= 32'h0;
            readReg1_out  <= 5'd0;
            readReg2_out  <= 5'd1;
          end else begin
            idx           <= idx_nxt;
            writeReg_out  <= idx_nxt;
            writeData_out <= expected(idx_nxt, invert);
          end
        end
        READ: begin
          fail_count_out <= fc_next;
          // fail_count of zero means nothing has failed yet (it saturates, never wraps)
          if (fail_count_out == 7'd0) begin
            if (mis1)      first_fail_out <= rd1_idx;
            else if (mis2) first_fail_out <= rd2_idx;
          end
          if (idx == 5'd15) begin
            idx          <= 5'd0;
            readReg1_out <= 5'd0;
            readReg2_out <= 5'd0;
            if (!last_pass) begin
`ifdef REGBIST_INVERT_PASS_EN
              invert       <= 1'b1;
`endif
              state         <= WRITE;
              enable_out    <= 1'b1;
              writeReg_out  <= 5'd0;
              writeData_out <= expected(5'd0, 1'b1);
            end else begin
              state    <= DONE;
              busy_out <= 1'b0;
              done_out <= 1'b1;
              pass_out <= (fc_next == 7'd0);
            end
          end else begin
            idx          <= idx_nxt;
            readReg1_out <= {idx_nxt[3:0], 1'b0};
            readReg2_out <= {idx_nxt[3:0], 1'b1};
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_bist.sv
// tb/tb_regfile_bist.sv - scoreboard bench for regfile_bist with faulty regfile model
module tb_regfile_bist;

  localparam logic [31:0] TB_SEED = 32'hA5A5_A5A4;
  localparam int          TB_ZHW  = 1;
`ifdef REGBIST_INVERT_PASS_EN
  localparam int NPASS = 2;
`else
  localparam int NPASS = 1;
`endif
  localparam int LAT = 48 * NPASS;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        enable_out;
  logic [4:0]  writeReg_out;
  logic [31:0] writeData_out;
  logic [4:0]  readReg1_out;
  logic [4:0]  readReg2_out;
  logic [31:0] data1;
  logic [31:0] data2;
  logic        busy_out;
  logic        done_out;
  logic        pass_out;
  logic [6:0]  fail_count_out;
  logic [4:0]  first_fail_out;

  logic [31:0] regs [32];
  logic [31:0] am   [32];
  logic [31:0] om   [32];

  typedef struct { logic [4:0] a; logic [31:0] d; } wr_t;
  typedef struct { int fc; int ff; bit pass; int cyc; } res_t;

  wr_t  wq[$];
  res_t rq[$];

  int cyc = 0;
  int passed = 0;
  int total = 0;
  logic done_prev = 1'b0;

  regfile_bist #(.SEED(TB_SEED), .ZERO_REG_HW(TB_ZHW)) dut (
    .clk(clk), .reset(reset), .start_in(start),
    .enable_out(enable_out), .writeReg_out(writeReg_out), .writeData_out(writeData_out),
    .readReg1_out(readReg1_out), .readReg2_out(readReg2_out),
    .data1_in(data1), .data2_in(data2),
    .busy_out(busy_out), .done_out(done_out), .pass_out(pass_out),
    .fail_count_out(fail_count_out), .first_fail_out(first_fail_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Register file with hardwired reg 0 and per-register read fault masks
  always @(posedge clk)
    if (enable_out && !(TB_ZHW != 0 && writeReg_out == 5'd0))
      regs[writeReg_out] <= writeData_out;

  assign data1 = (((TB_ZHW != 0 && readReg1_out == 5'd0) ? 32'h0 : regs[readReg1_out])
                  & am[readReg1_out]) | om[readReg1_out];
  assign data2 = (((TB_ZHW != 0 && readReg2_out == 5'd0) ? 32'h0 : regs[readReg2_out])
                  & am[readReg2_out]) | om[readReg2_out];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [31:0] pat(input int i, input int p);
    logic [31:0] v;
    if (TB_ZHW != 0 && i == 0) return 32'h0;
    v = 32'(i) ^ TB_SEED;
    return (p != 0) ? ~v : v;
  endfunction

  // Expected writes and final result for a run whose start is driven now
  task automatic expect_run(input int now_cyc);
    int fc, ff;
    bit found;
    logic [31:0] w, rd;
    wr_t e;
    res_t r;
    fc = 0; ff = 0; found = 0;
    for (int p = 0; p < NPASS; p++) begin
      for (int i = 0; i < 32; i++) begin
        w = pat(i, p);
        e.a = i[4:0];
        e.d = w;
        wq.push_back(e);
        rd = (TB_ZHW != 0 && i == 0) ? 32'h0 : w;
        rd = (rd & am[i]) | om[i];
        if (rd != w) begin
          if (!found) ff = i;
          found = 1;
          fc++;
        end
      end
    end
    if (fc > 127) fc = 127;
    r.fc = fc; r.ff = ff; r.pass = (fc == 0); r.cyc = now_cyc + 1 + LAT;
    rq.push_back(r);
  endtask

  // Scoreboard monitor: pops expectations whenever the DUT writes or finishes
  always @(negedge clk) begin
    wr_t e;
    res_t r;
    if (reset) begin
      if (enable_out) begin
        if (wq.size() == 0) check("unexpected_write", 64'(writeReg_out), 64'hDEAD);
        else begin
          e = wq.pop_front();
          check("write_addr", 64'(writeReg_out), 64'(e.a));
          check("write_data", 64'(writeData_out), 64'(e.d));
        end
      end
      if (done_out && !done_prev) begin
        if (rq.size() == 0) check("unexpected_done", 64'(done_out), 64'd0);
        else begin
          r = rq.pop_front();
          check("done_latency", 64'(cyc), 64'(r.cyc));
          check("fail_count", 64'(fail_count_out), 64'(r.fc));
          check("first_fail", 64'(first_fail_out), 64'(r.ff));
          check("pass", 64'(pass_out), 64'(r.pass));
          check("busy_at_done", 64'(busy_out), 64'd0);
        end
      end
    end
    done_prev <= done_out;
  end

  task automatic clear_masks();
    for (int i = 0; i < 32; i++) begin
      am[i] = 32'hFFFF_FFFF;
      om[i] = 32'h0;
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_enable"}, 64'(enable_out), 64'd0);
    check({tag, "_wreg"}, 64'(writeReg_out), 64'd0);
    check({tag, "_wdata"}, 64'(writeData_out), 64'd0);
    check({tag, "_rreg1"}, 64'(readReg1_out), 64'd0);
    check({tag, "_rreg2"}, 64'(readReg2_out), 64'd0);
    check({tag, "_busy"}, 64'(busy_out), 64'd0);
    check({tag, "_done"}, 64'(done_out), 64'd0);
    check({tag, "_pass"}, 64'(pass_out), 64'd0);
    check({tag, "_fcount"}, 64'(fail_count_out), 64'd0);
    check({tag, "_ffirst"}, 64'(first_fail_out), 64'd0);
  endtask

  task automatic wait_done(input bit rand_start);
    int t;
    t = 0;
    while (!done_out && t < 400) begin
      if (rand_start) start = (t < LAT - 4) && ($urandom_range(0, 3) == 0);
      @(posedge clk); #1;
      t++;
    end
    if (rand_start) start = 1'b0;
    check("done_seen", 64'(done_out), 64'd1);
  endtask

  task automatic do_run(input bit rand_start);
    expect_run(cyc);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(rand_start);
    @(posedge clk); #1;
  endtask

  initial begin
    int mode, r1, r2;
    reset = 1'b0;
    start = 1'b0;
    clear_masks();
    repeat (2) @(posedge clk);
    #1;
    check_idle("reset");
    reset = 1'b1;
    @(posedge clk); #1;

    // Ideal regfile
    do_run(1'b0);

    // Reg 7 bit 0 stuck-at-0
    am[7] = 32'hFFFF_FFFE;
    do_run(1'b0);
    clear_masks();

    // Regs 4 and 5 read as zero in the same pair
    am[4] = 32'h0;
    am[5] = 32'h0;
    do_run(1'b0);
    clear_masks();

    // Reset during WRITE aborts the run
    expect_run(cyc);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    wq.delete();
    rq.delete();
    check_idle("abort");
    reset = 1'b1;
    do_run(1'b0);

    // start held high: single run while busy, then immediate restart
    am[7] = 32'hFFFF_FFFE;
    expect_run(cyc);
    start = 1'b1;
    @(posedge clk); #1;
    wait_done(1'b0);
    expect_run(cyc);
    @(posedge clk); #1;
    check("restart_busy", 64'(busy_out), 64'd1);
    check("restart_done", 64'(done_out), 64'd0);
    check("restart_fcount", 64'(fail_count_out), 64'd0);
    check("restart_ffirst", 64'(first_fail_out), 64'd0);
    start = 1'b0;
    wait_done(1'b0);
    @(posedge clk); #1;
    clear_masks();

    // Randomized fault configurations with stray start pulses while busy
    for (int n = 0; n < 8; n++) begin
      mode = $urandom_range(0, 3);
      r1 = $urandom_range(0, 31);
      r2 = $urandom_range(0, 31);
      case (mode)
        1: am[r1] = ~(32'h1 << $urandom_range(0, 31));
        2: om[r1] = 32'h1 << $urandom_range(0, 31);
        3: begin am[r1] = 32'h0; am[r2] = 32'h0; end
        default: ;
      endcase
      do_run(1'b1);
      clear_masks();
    end

    repeat (3) @(posedge clk);
    #1;
    check("writes_drained", 64'(wq.size()), 64'd0);
    check("results_drained", 64'(rq.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
